// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter: 8-entry scan-code FIFO feeding an
// 11-bit frame serialiser that drives both ps2_clk and ps2_data.
module ps2_kbd_tx #(
  parameter int CLK_DIV = 2000,
  parameter int GAP_CYC = 4000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       inhibit,
  output logic       full,
  output logic       busy,
  output logic       overflow,
  output logic [7:0] frames_sent,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam int PH_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int PH_W   = $clog2(PH_MAX);
  localparam logic [PH_W-1:0] DIV_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] GAP_LAST = PH_W'(GAP_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_HI, S_LO, S_GAP} state_t;

  logic [7:0]      mem_q [8];
  logic [2:0]      wr_ptr_q, rd_ptr_q;
  logic [3:0]      count_q, count_d;
  state_t          state_q, state_d;
  logic [10:0]     sr_q;
  logic [3:0]      bit_q;
  logic [PH_W-1:0] ph_q;
  logic            full_q, busy_q, ovf_q, clk_q, data_q;
  logic [7:0]      frames_q;

  logic            wr_ok, pop, ph_end_div, ph_end_gap;
  logic [7:0]      head;
  logic [10:0]     frame;

  assign wr_ok      = wr_en & ~full_q;
  assign pop        = (state_q == S_IDLE) & (count_q != 4'd0) & ~inhibit;
  assign count_d    = count_q + {3'b000, wr_ok} - {3'b000, pop};
  assign ph_end_div = (ph_q == DIV_LAST);
  assign ph_end_gap = (ph_q == GAP_LAST);
  assign head       = mem_q[rd_ptr_q];
  // Bit 0 goes out first: start 0, data LSB first, odd parity, stop 1.
  assign frame      = {1'b1, ~^head, head, 1'b0};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pop) state_d = S_HI;
      S_HI:    if (ph_end_div) state_d = S_LO;
      S_LO:    if (ph_end_div) state_d = (bit_q == 4'd10) ? S_GAP : S_HI;
      S_GAP:   if (ph_end_gap) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr_q <= 3'd0;
      rd_ptr_q <= 3'd0;
      count_q  <= 4'd0;
      full_q   <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      frames_q <= 8'd0;
      state_q  <= S_IDLE;
      sr_q     <= 11'h7FF;
      bit_q    <= 4'd0;
      ph_q     <= '0;
      clk_q    <= 1'b1;
      data_q   <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 3'd1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 3'd1;
      count_q <= count_d;
      full_q  <= (count_d == 4'd8);
      busy_q  <= (state_d != S_IDLE) || (count_d != 4'd0);
      // A rejected write is flagged even when a pop frees a slot this cycle.
      if (wr_en && full_q) ovf_q <= 1'b1;
      state_q <= state_d;

      case (state_q)
        S_IDLE: begin
          clk_q  <= 1'b1;
          data_q <= 1'b1;
          if (pop) begin
            sr_q  <= frame;
            bit_q <= 4'd0;
            ph_q  <= '0;
          end
        end
        S_HI: begin
          data_q <= sr_q[0];
          clk_q  <= ~ph_end_div;
          ph_q   <= ph_end_div ? '0 : ph_q + PH_W'(1);
        end
        S_LO: begin
          clk_q <= 1'b0;
          if (ph_end_div) begin
            ph_q  <= '0;
            clk_q <= 1'b1;
            if (bit_q == 4'd10) begin
              data_q   <= 1'b1;
              frames_q <= frames_q + 8'd1;
            end else begin
              // Data moves only together with the rising clock edge.
              bit_q  <= bit_q + 4'd1;
              sr_q   <= {1'b1, sr_q[10:1]};
              data_q <= sr_q[1];
            end
          end else begin
            ph_q <= ph_q + PH_W'(1);
          end
        end
        S_GAP: begin
          clk_q  <= 1'b1;
          data_q <= 1'b1;
          ph_q   <= ph_end_gap ? '0 : ph_q + PH_W'(1);
        end
        default: begin
          clk_q  <= 1'b1;
          data_q <= 1'b1;
        end
      endcase
    end
  end

  assign full        = full_q;
  assign busy        = busy_q;
  assign overflow    = ovf_q;
  assign frames_sent = frames_q;
  assign ps2_clk     = clk_q;
  assign ps2_data    = data_q;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx: frame-timeline model checked every cycle, a host-side
// receiver for loopback, and directed scenarios with literal expectations.
module tb_ps2_kbd_tx;

  localparam int D = 4;
  localparam int G = 8;
  localparam int FRAME = 22 * D;

  logic       clk = 1'b0;
  logic       clr;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       inhibit = 1'b0;
  logic       full, busy, overflow, ps2_clk, ps2_data;
  logic [7:0] frames_sent;

  ps2_kbd_tx #(.CLK_DIV(D), .GAP_CYC(G)) dut (
    .clk(clk), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .inhibit(inhibit),
    .full(full), .busy(busy), .overflow(overflow), .frames_sent(frames_sent),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: timeline of each frame ----------------
  logic [7:0] mq[$];
  logic [7:0] cur = 8'h00;
  int         e = 0;
  int         fstart = -1;
  int         m_frames = 0;
  logic       m_ovf = 1'b0;

  function automatic logic fbit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9) return ~^b;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge clr) begin
    int sz;
    logic idle_before, do_pop;
    if (clr) begin
      mq.delete();
      fstart   = -1;
      m_frames = 0;
      m_ovf    = 1'b0;
      e        = 0;
    end else begin
      e++;
      idle_before = (fstart < 0) || ((e - 1 - fstart) >= FRAME + G);
      sz = mq.size();
      do_pop = idle_before && (sz > 0) && !inhibit;
      if (wr_en && sz == 8) m_ovf = 1'b1;
      if (do_pop) begin
        cur = mq.pop_front();
        fstart = e;
      end
      if (wr_en && sz < 8) mq.push_back(wr_data);
      if (fstart >= 0 && (e - fstart) == FRAME) m_frames = (m_frames + 1) % 256;
    end
  end

  always @(negedge clk) begin
    int n;
    logic ec, ed, eb;
    n = e - fstart;
    if (fstart < 0 || n == 0 || n >= FRAME) begin
      ec = 1'b1;
      ed = 1'b1;
    end else begin
      ec = ((n % (2 * D)) < D);
      ed = fbit(cur, n / (2 * D));
    end
    eb = ((fstart >= 0) && (n < FRAME + G)) || (mq.size() > 0);
    chk("ps2_clk", ps2_clk, ec);
    chk("ps2_data", ps2_data, ed);
    chk("busy", busy, eb);
    chk("full", full, mq.size() == 8);
    chk("overflow", overflow, m_ovf);
    chk("frames_sent", frames_sent, m_frames);
  end

  // ---------------- host-side receiver ----------------
  logic [7:0]  rx_q[$];
  logic        rx_par[$];
  longint      rx_t0[$];
  logic [10:0] rx_sh = '0;
  logic [10:0] rx_last = '0;
  int          rx_cnt = 0;
  int          rx_err = 0;

  always @(negedge ps2_clk or posedge clr) begin
    if (clr) begin
      rx_cnt = 0;
    end else begin
      if (rx_cnt == 0) rx_t0.push_back($time);
      rx_sh[rx_cnt] = ps2_data;
      rx_cnt++;
      if (rx_cnt == 11) begin
        if (rx_sh[0] !== 1'b0 || rx_sh[10] !== 1'b1 || rx_sh[9] !== ~^rx_sh[8:1]) rx_err++;
        rx_q.push_back(rx_sh[8:1]);
        rx_par.push_back(rx_sh[9]);
        rx_last = rx_sh;
        rx_cnt = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    inhibit = 1'b0;
    step(1);
    clr = 1'b1;
    step(2);
    clr = 1'b0;
    rx_q.delete();
    rx_par.delete();
    rx_t0.delete();
    rx_err = 0;
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      step(1);
      k++;
    end
    if (rx_q.size() < n) chk("rx_timeout", rx_q.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      step(1);
      k++;
    end
    if (busy !== 1'b0) chk("idle_timeout", busy, 0);
  endtask

  initial begin
    logic [10:0] exp_bits;
    int t0, k;
    int wrote, guard;

    clr = 1'b1;
    step(2);
    clr = 1'b0;
    chk("rst_ps2_clk", ps2_clk, 1);
    chk("rst_ps2_data", ps2_data, 1);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frames", frames_sent, 0);

    // 1: single byte 0x1C, bits at falling edges 0,0,0,1,1,1,0,0,0,0,1
    do_reset();
    wr(8'h1C);
    t0 = cyc;
    k = 0;
    while (frames_sent !== 8'd1 && k < 300) begin
      step(1);
      k++;
    end
    chk("t1_span", cyc - t0, 1 + 88);
    exp_bits = 11'b100_0011_1000;
    for (int i = 0; i < 11; i++) chk("t1_bit", rx_last[i], exp_bits[i]);
    chk("t1_frames", frames_sent, 1);
    wait_idle(50);

    // 2: loopback of three bytes back-to-back
    do_reset();
    wr(8'hF0);
    wr(8'h1C);
    wr(8'h00);
    wait_rx(3, 600);
    wait_idle(100);
    if (rx_q.size() == 3) begin
      chk("t2_b0", rx_q[0], 8'hF0);
      chk("t2_b1", rx_q[1], 8'h1C);
      chk("t2_b2", rx_q[2], 8'h00);
      chk("t2_p0", rx_par[0], 1);
      chk("t2_p1", rx_par[1], 0);
      chk("t2_p2", rx_par[2], 1);
      chk("t2_space01", (rx_t0[1] - rx_t0[0]) / 10, 97);
      chk("t2_space12", (rx_t0[2] - rx_t0[1]) / 10, 97);
    end
    chk("t2_rx_err", rx_err, 0);

    // 3: overflow while inhibited
    do_reset();
    inhibit = 1'b1;
    for (int i = 1; i <= 8; i++) wr(8'(i));
    chk("t3_full8", full, 1);
    chk("t3_ovf8", overflow, 0);
    wr(8'h09);
    chk("t3_full9", full, 1);
    chk("t3_ovf9", overflow, 1);
    inhibit = 1'b0;
    wait_rx(8, 1200);
    wait_idle(200);
    step(150);
    chk("t3_count", rx_q.size(), 8);
    for (int i = 0; i < 8 && i < rx_q.size(); i++) chk("t3_byte", rx_q[i], i + 1);
    chk("t3_ovf_sticky", overflow, 1);
    chk("t3_frames", frames_sent, 8);

    // 4: inhibit before start, then raised mid-frame
    do_reset();
    inhibit = 1'b1;
    wr(8'h2A);
    step(50);
    chk("t4_clk_hold", ps2_clk, 1);
    chk("t4_data_hold", ps2_data, 1);
    chk("t4_busy_hold", busy, 1);
    inhibit = 1'b0;
    t0 = cyc;
    k = 0;
    while (ps2_data !== 1'b0 && k < 20) begin
      step(1);
      k++;
    end
    chk("t4_start_delay", cyc - t0, 2);
    step(30);
    inhibit = 1'b1;
    wr(8'h55);
    wait_rx(1, 200);
    step(150);
    chk("t4_held_count", rx_q.size(), 1);
    chk("t4_held_busy", busy, 1);
    inhibit = 1'b0;
    wait_rx(2, 300);
    wait_idle(100);
    if (rx_q.size() == 2) begin
      chk("t4_b0", rx_q[0], 8'h2A);
      chk("t4_b1", rx_q[1], 8'h55);
    end
    chk("t4_rx_err", rx_err, 0);

    // 5: reset during bit 4 LO with three bytes queued
    do_reset();
    for (int i = 0; i < 4; i++) wr(8'h11 * (i + 1));
    k = 0;
    while (rx_cnt != 5 && k < 200) begin
      step(1);
      k++;
    end
    chk("t5_reach_bit4", rx_cnt, 5);
    step(1);
    chk("t5_pre_clk", ps2_clk, 0);
    clr = 1'b1;
    #1;
    chk("t5_async_clk", ps2_clk, 1);
    chk("t5_async_data", ps2_data, 1);
    step(2);
    clr = 1'b0;
    step(1);
    chk("t5_busy", busy, 0);
    step(300);
    chk("t5_no_frames", rx_q.size(), 0);
    chk("t5_frames", frames_sent, 0);

    // 6: 257 frames, pointers and frames_sent wrap
    do_reset();
    wrote = 0;
    guard = 0;
    while (wrote < 257 && guard < 40000) begin
      if (!full) begin
        wr_en = 1'b1;
        wr_data = 8'(wrote);
        wrote++;
      end else begin
        wr_en = 1'b0;
      end
      step(1);
      guard++;
    end
    wr_en = 1'b0;
    wait_rx(257, 2000);
    wait_idle(200);
    chk("t6_frames", frames_sent, 1);
    chk("t6_rx_err", rx_err, 0);
    for (int i = 0; i < 257 && i < rx_q.size(); i++) chk("t6_byte", rx_q[i], i % 256);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
